// File: rtl/axi_mux_pkg.sv
// Shared types and constants for the AXI master multiplexer.
package axi_mux_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAr,
    StR,
    StAw,
    StW,
    StB
  } state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Width of an index able to name any of n clients (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_mux_arb.sv
// N-way arbiter: round-robin starting at ptr_i by default, or fixed lowest-index-wins priority
// when AXI_MUX_FIXED_PRIO_EN is defined (ptr_i is then ignored).
module axi_mux_arb
  import axi_mux_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

`ifdef AXI_MUX_FIXED_PRIO_EN
  // Scan downwards so the lowest requesting index is the last (winning) assignment.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_o     = '0;
        gnt_o[i]  = 1'b1;
        gnt_idx_o = IW'(i);
      end
    end
  end
`else
  int   cand;
  logic found;

  // Walk the clients starting at ptr_i, wrapping once; first requester wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < int'(N); k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= int'(N)) cand = cand - int'(N);
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        gnt_o[cand]  = 1'b1;
        gnt_idx_o    = IW'(cand);
      end
    end
  end
`endif

endmodule

// File: rtl/axi_master_mux.sv
// N-client to single AXI4 master multiplexer, one transaction in flight.
// Define AXI_MUX_FIXED_PRIO_EN for fixed (lowest index) priority instead of round-robin.
module axi_master_mux
  import axi_mux_pkg::*;
#(
  parameter int unsigned N_CLIENT = 3,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ID_W     = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  // Client request
  input  logic [N_CLIENT-1:0]          req_valid,
  output logic [N_CLIENT-1:0]          req_ready,
  input  logic [N_CLIENT-1:0]          req_write,
  input  logic [32*N_CLIENT-1:0]       req_addr,
  input  logic [8*N_CLIENT-1:0]        req_len,
  input  logic [3*N_CLIENT-1:0]        req_size,
  // Client write data
  input  logic [N_CLIENT-1:0]          wd_valid,
  output logic [N_CLIENT-1:0]          wd_ready,
  input  logic [N_CLIENT-1:0]          wd_last,
  input  logic [N_CLIENT*DATA_W-1:0]   wd_data,
  input  logic [N_CLIENT*DATA_W/8-1:0] wd_strb,
  // Client response
  output logic [N_CLIENT-1:0]          rsp_valid,
  input  logic [N_CLIENT-1:0]          rsp_ready,
  output logic [DATA_W-1:0]            rsp_data,
  output logic                         rsp_last,
  output logic                         rsp_err,
  // AXI write address
  output logic [ID_W-1:0]              awid,
  output logic [31:0]                  awaddr,
  output logic [7:0]                   awlen,
  output logic [2:0]                   awsize,
  output logic [1:0]                   awburst,
  output logic                         awlock,
  output logic [3:0]                   awcache,
  output logic [2:0]                   awprot,
  output logic [3:0]                   awqos,
  output logic                         awuser,
  output logic                         awvalid,
  input  logic                         awready,
  // AXI write data
  output logic [DATA_W-1:0]            wdata,
  output logic [DATA_W/8-1:0]          wstrb,
  output logic                         wlast,
  output logic                         wvalid,
  input  logic                         wready,
  // AXI write response
  input  logic [1:0]                   bresp,
  input  logic                         bvalid,
  output logic                         bready,
  // AXI read address
  output logic [ID_W-1:0]              arid,
  output logic [31:0]                  araddr,
  output logic [7:0]                   arlen,
  output logic [2:0]                   arsize,
  output logic [1:0]                   arburst,
  output logic                         arlock,
  output logic [3:0]                   arcache,
  output logic [2:0]                   arprot,
  output logic [3:0]                   arqos,
  output logic                         aruser,
  output logic                         arvalid,
  input  logic                         arready,
  // AXI read data
  input  logic [DATA_W-1:0]            rdata,
  input  logic [1:0]                   rresp,
  input  logic                         rlast,
  input  logic                         rvalid,
  output logic                         rready
);

  localparam int unsigned IW     = idx_width(N_CLIENT);
  localparam int unsigned STRB_W = DATA_W / 8;

  state_e              state_q, state_d;
  logic [IW-1:0]       owner_q, rr_ptr_q, rr_ptr_d;
  logic [31:0]         addr_q;
  logic [7:0]          len_q;
  logic [2:0]          size_q;

  logic [N_CLIENT-1:0] gnt;
  logic [IW-1:0]       gnt_idx;
  logic                grant_fire;
  logic [31:0]         sel_addr;
  logic [7:0]          sel_len;
  logic [2:0]          sel_size;
  logic                sel_write;

  logic [N_CLIENT-1:0] owner_oh;
  logic                own_rsp_ready, own_wd_valid, own_wd_last;
  logic [DATA_W-1:0]   own_wd_data;
  logic [STRB_W-1:0]   own_wd_strb;

  axi_mux_arb #(
    .N  (N_CLIENT),
    .IW (IW)
  ) u_arb (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign grant_fire = (state_q == StIdle) && (|req_valid);
  assign rr_ptr_d   = (gnt_idx == IW'(N_CLIENT - 1)) ? '0 : gnt_idx + IW'(1);

  // Pick the granted client's request fields (grant is one-hot).
  always_comb begin
    sel_addr  = '0;
    sel_len   = '0;
    sel_size  = '0;
    sel_write = 1'b0;
    for (int i = 0; i < int'(N_CLIENT); i++) begin
      if (gnt[i]) begin
        sel_addr  = req_addr[i*32 +: 32];
        sel_len   = req_len[i*8 +: 8];
        sel_size  = req_size[i*3 +: 3];
        sel_write = req_write[i];
      end
    end
  end

  // Route the owning client's inputs onto internal buses.
  always_comb begin
    owner_oh      = '0;
    own_rsp_ready = 1'b0;
    own_wd_valid  = 1'b0;
    own_wd_last   = 1'b0;
    own_wd_data   = '0;
    own_wd_strb   = '0;
    for (int i = 0; i < int'(N_CLIENT); i++) begin
      if (owner_q == IW'(i)) begin
        owner_oh[i]   = 1'b1;
        own_rsp_ready = rsp_ready[i];
        own_wd_valid  = wd_valid[i];
        own_wd_last   = wd_last[i];
        own_wd_data   = wd_data[i*DATA_W +: DATA_W];
        own_wd_strb   = wd_strb[i*STRB_W +: STRB_W];
      end
    end
  end

  // State, latched request and round-robin pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant_fire) begin
        owner_q  <= gnt_idx;
        addr_q   <= sel_addr;
        len_q    <= sel_len;
        size_q   <= sel_size;
        rr_ptr_q <= rr_ptr_d;
      end
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    wd_ready  = '0;
    rsp_valid = '0;
    rsp_data  = '0;
    rsp_last  = 1'b0;
    rsp_err   = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    wdata     = '0;
    wstrb     = '0;
    wlast     = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          req_ready = gnt;
          state_d   = sel_write ? StAw : StAr;
        end
      end
      StAr: begin
        arvalid = 1'b1;
        if (arready) state_d = StR;
      end
      StR: begin
        rready    = own_rsp_ready;
        rsp_valid = owner_oh & {N_CLIENT{rvalid}};
        rsp_data  = rdata;
        rsp_last  = rlast;
        rsp_err   = rresp[1];
        if (rvalid && own_rsp_ready && rlast) state_d = StIdle;
      end
      StAw: begin
        awvalid = 1'b1;
        if (awready) state_d = StW;
      end
      StW: begin
        wvalid   = own_wd_valid;
        wd_ready = owner_oh & {N_CLIENT{wready}};
        wdata    = own_wd_data;
        wstrb    = own_wd_strb;
        wlast    = own_wd_last;
        if (own_wd_valid && wready && own_wd_last) state_d = StB;
      end
      StB: begin
        bready    = own_rsp_ready;
        rsp_valid = owner_oh & {N_CLIENT{bvalid}};
        rsp_last  = 1'b1;
        rsp_err   = bresp[1];
        if (bvalid && own_rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign awid    = ID_W'(owner_q);
  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = size_q;
  assign awburst = BURST_INCR;
  assign awlock  = 1'b0;
  assign awcache = '0;
  assign awprot  = '0;
  assign awqos   = '0;
  assign awuser  = 1'b0;

  assign arid    = ID_W'(owner_q);
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = size_q;
  assign arburst = BURST_INCR;
  assign arlock  = 1'b0;
  assign arcache = '0;
  assign arprot  = '0;
  assign arqos   = '0;
  assign aruser  = 1'b0;

endmodule

// File: tb/tb_axi_master_mux.sv
// Self-checking bench for axi_master_mux: vector table, contention, random arbitration against
// a reference model, and reset during a write burst.
`define CHK(n, a, e) chk(n, 64'(a), 64'(e))

module tb_axi_master_mux;
  import axi_mux_pkg::*;

  localparam int N   = 3;
  localparam int DW  = 64;
  localparam int SW  = DW / 8;
  localparam int IDW = 1;

  logic              clock, reset;
  logic [N-1:0]      req_valid, req_ready, req_write;
  logic [32*N-1:0]   req_addr;
  logic [8*N-1:0]    req_len;
  logic [3*N-1:0]    req_size;
  logic [N-1:0]      wd_valid, wd_ready, wd_last;
  logic [N*DW-1:0]   wd_data;
  logic [N*SW-1:0]   wd_strb;
  logic [N-1:0]      rsp_valid, rsp_ready;
  logic [DW-1:0]     rsp_data;
  logic              rsp_last, rsp_err;
  logic [IDW-1:0]    awid, arid;
  logic [31:0]       awaddr, araddr;
  logic [7:0]        awlen, arlen;
  logic [2:0]        awsize, arsize, awprot, arprot;
  logic [1:0]        awburst, arburst, bresp, rresp;
  logic              awlock, arlock, awuser, aruser;
  logic [3:0]        awcache, arcache, awqos, arqos;
  logic              awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic              arvalid, arready, rvalid, rready, rlast;
  logic [DW-1:0]     wdata, rdata;
  logic [SW-1:0]     wstrb;

  axi_master_mux #(
    .N_CLIENT (N),
    .DATA_W   (DW),
    .ID_W     (IDW)
  ) dut (
    .clock     (clock),     .reset     (reset),
    .req_valid (req_valid), .req_ready (req_ready), .req_write (req_write),
    .req_addr  (req_addr),  .req_len   (req_len),   .req_size  (req_size),
    .wd_valid  (wd_valid),  .wd_ready  (wd_ready),  .wd_last   (wd_last),
    .wd_data   (wd_data),   .wd_strb   (wd_strb),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),  .rsp_err   (rsp_err),
    .awid      (awid),      .awaddr    (awaddr),    .awlen     (awlen),
    .awsize    (awsize),    .awburst   (awburst),   .awlock    (awlock),
    .awcache   (awcache),   .awprot    (awprot),    .awqos     (awqos),
    .awuser    (awuser),    .awvalid   (awvalid),   .awready   (awready),
    .wdata     (wdata),     .wstrb     (wstrb),     .wlast     (wlast),
    .wvalid    (wvalid),    .wready    (wready),
    .bresp     (bresp),     .bvalid    (bvalid),    .bready    (bready),
    .arid      (arid),      .araddr    (araddr),    .arlen     (arlen),
    .arsize    (arsize),    .arburst   (arburst),   .arlock    (arlock),
    .arcache   (arcache),   .arprot    (arprot),    .arqos     (arqos),
    .aruser    (aruser),    .arvalid   (arvalid),   .arready   (arready),
    .rdata     (rdata),     .rresp     (rresp),     .rlast     (rlast),
    .rvalid    (rvalid),    .rready    (rready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;
  int mptr     = 0;  // model round-robin pointer
  logic [31:0] m_addr [N];
  logic [7:0]  m_len  [N];

  typedef struct {
    int          c;
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    int          delay;
    int          err_beat;
    int          stall_beat;
    logic [1:0]  br;
    logic [0:0]  exp_id;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [N-1:0] onehot(input int c);
    logic [N-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  function automatic logic [IDW-1:0] id_of(input int c);
    return c[IDW-1:0];
  endfunction

  // Reference arbitration: first requester scanning from the pointer (or lowest index).
  function automatic int pick(input logic [N-1:0] mask, input int ptr);
`ifdef AXI_MUX_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (mask[k]) return k;
`else
    for (int k = 0; k < N; k++) if (mask[(ptr + k) % N]) return (ptr + k) % N;
`endif
    return -1;
  endfunction

  task automatic set_req(input int c, input logic [31:0] a, input logic [7:0] l);
    m_addr[c]            = a;
    m_len[c]             = l;
    req_addr[c*32 +: 32] = a;
    req_len[c*8 +: 8]    = l;
    req_size[c*3 +: 3]   = 3'd3;
  endtask

  task automatic grant(input logic [N-1:0] mask, input logic [N-1:0] wr, input int exp_c,
                       input bit keep);
    req_valid = mask;
    req_write = wr;
    @(negedge clock);
    `CHK("grant", req_ready, onehot(exp_c));
    cyc();
    if (!keep) req_valid = '0;
    mptr = (exp_c + 1) % N;
  endtask

  task automatic read_body(input int c, input logic [31:0] a, input logic [7:0] len,
                           input int dly, input int err_beat, input int stall_beat,
                           input logic [IDW-1:0] id);
    logic [63:0] d;
    logic [1:0]  rr;
    for (int i = 0; i < dly; i++) begin
      @(negedge clock);
      `CHK("ar_hold_valid", arvalid, 1);
      `CHK("ar_hold_addr", araddr, a);
      cyc();
    end
    arready = 1'b1;
    @(negedge clock);
    `CHK("arvalid", arvalid, 1);
    `CHK("araddr", araddr, a);
    `CHK("arlen", arlen, len);
    `CHK("arid", arid, id);
    `CHK("arburst", arburst, BURST_INCR);
    `CHK("busy_no_grant", req_ready, 0);
    cyc();
    arready = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      d      = {$urandom, $urandom};
      rr     = (b == err_beat) ? RESP_SLVERR : (($urandom % 2) ? RESP_EXOKAY : RESP_OKAY);
      rvalid = 1'b1;
      rdata  = d;
      rresp  = rr;
      rlast  = (b == int'(len));
      if (b == stall_beat) begin
        rsp_ready[c] = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clock);
          `CHK("stall_rready", rready, 0);
          `CHK("stall_rsp_valid", rsp_valid, onehot(c));
          cyc();
        end
        rsp_ready[c] = 1'b1;
      end
      @(negedge clock);
      `CHK("r_rsp_valid", rsp_valid, onehot(c));
      `CHK("r_rsp_data", rsp_data, d);
      `CHK("r_rsp_last", rsp_last, (b == int'(len)));
      `CHK("r_rsp_err", rsp_err, (b == err_beat));
      `CHK("r_rready", rready, 1);
      `CHK("r_no_arvalid", arvalid, 0);
      `CHK("r_no_grant", req_ready, 0);
      cyc();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  task automatic write_body(input int c, input logic [31:0] a, input logic [7:0] len,
                            input int dly, input logic [1:0] br, input logic [IDW-1:0] id);
    logic [63:0] d;
    logic [7:0]  st;
    d                   = {$urandom, $urandom};
    wd_valid[c]         = 1'b1;
    wd_data[c*DW +: DW] = d;
    wd_strb[c*SW +: SW] = 8'hFF;
    wd_last[c]          = (len == 0);
    for (int i = 0; i < dly; i++) begin
      @(negedge clock);
      `CHK("aw_hold_valid", awvalid, 1);
      `CHK("aw_hold_addr", awaddr, a);
      `CHK("w_before_aw", wvalid, 0);
      cyc();
    end
    awready = 1'b1;
    wready  = 1'b1;
    @(negedge clock);
    `CHK("awvalid", awvalid, 1);
    `CHK("awaddr", awaddr, a);
    `CHK("awlen", awlen, len);
    `CHK("awid", awid, id);
    `CHK("w_before_aw", wvalid, 0);
    `CHK("wd_ready_before_aw", wd_ready, 0);
    cyc();
    awready = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      if (b > 0) d = {$urandom, $urandom};
      st                  = (b == 0) ? 8'hFF : 8'($urandom);
      wd_data[c*DW +: DW] = d;
      wd_strb[c*SW +: SW] = st;
      wd_last[c]          = (b == int'(len));
      @(negedge clock);
      `CHK("wvalid", wvalid, 1);
      `CHK("wdata", wdata, d);
      `CHK("wstrb", wstrb, st);
      `CHK("wlast", wlast, (b == int'(len)));
      `CHK("wd_ready", wd_ready, onehot(c));
      cyc();
    end
    wd_valid[c] = 1'b0;
    wd_last[c]  = 1'b0;
    wready      = 1'b0;
    bvalid      = 1'b1;
    bresp       = br;
    @(negedge clock);
    `CHK("b_rsp_valid", rsp_valid, onehot(c));
    `CHK("b_rsp_last", rsp_last, 1);
    `CHK("b_rsp_err", rsp_err, br[1]);
    `CHK("bready", bready, 1);
    `CHK("b_no_wvalid", wvalid, 0);
    cyc();
    bvalid = 1'b0;
  endtask

  task automatic idle_check();
    @(negedge clock);
    `CHK("idle_rsp_valid", rsp_valid, 0);
    `CHK("idle_arvalid", arvalid, 0);
    `CHK("idle_awvalid", awvalid, 0);
    `CHK("idle_req_ready", req_ready, 0);
    cyc();
  endtask

  vec_t vecs [6];
  int   ord_exp [6];

  initial begin
    reset     = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_len = '0; req_size = '0;
    wd_valid  = '0; wd_last = '0; wd_data = '0; wd_strb = '0;
    rsp_ready = '1;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;

    vecs[0] = '{1, 1'b0, 32'h8000_0000, 8'd3, 0, -1, -1, RESP_OKAY,   1'b1};
    vecs[1] = '{0, 1'b1, 32'h0000_1000, 8'd1, 0, -1, -1, RESP_OKAY,   1'b0};
    vecs[2] = '{2, 1'b0, 32'h2000_0040, 8'd3, 5, -1,  1, RESP_OKAY,   1'b0};
    vecs[3] = '{0, 1'b0, 32'h0000_0300, 8'd3, 1,  1, -1, RESP_OKAY,   1'b0};
    vecs[4] = '{1, 1'b1, 32'h0000_0400, 8'd2, 2, -1, -1, RESP_DECERR, 1'b1};
    vecs[5] = '{2, 1'b1, 32'h0000_0500, 8'd0, 0, -1, -1, RESP_SLVERR, 1'b0};
`ifdef AXI_MUX_FIXED_PRIO_EN
    ord_exp = '{0, 0, 0, 0, 0, 0};
`else
    ord_exp = '{0, 1, 2, 0, 1, 2};
`endif

    // Reset state
    #2;
    `CHK("rst_arvalid", arvalid, 0);
    `CHK("rst_awvalid", awvalid, 0);
    `CHK("rst_wvalid", wvalid, 0);
    `CHK("rst_req_ready", req_ready, 0);
    `CHK("rst_rsp_valid", rsp_valid, 0);
    `CHK("rst_araddr", araddr, 0);
    cyc();
    reset = 1'b1;
    cyc();

    // Contention: all clients requesting reads, pointer starts at 0
    for (int c = 0; c < N; c++) set_req(c, 32'h1000_0000 + 32'(c) * 32'h100, 8'd0);
    for (int g = 0; g < 6; g++) begin
      int w;
      w = pick('1, mptr);
      n_checks++;
      if (w !== ord_exp[g]) begin
        n_err++;
        $display("FAIL model_order: got %0d expected %0d at %0t", w, ord_exp[g], $time);
      end
      grant('1, '0, ord_exp[g], 1'b1);
      read_body(ord_exp[g], m_addr[ord_exp[g]], 8'd0, 0, -1, -1, id_of(ord_exp[g]));
    end
    req_valid = '0;
    idle_check();

    // Vector table
    for (int i = 0; i < 6; i++) begin
      set_req(vecs[i].c, vecs[i].addr, vecs[i].len);
      grant(onehot(vecs[i].c), vecs[i].wr ? onehot(vecs[i].c) : '0, vecs[i].c, 1'b0);
      n_checks++;
      if ((vecs[i].wr ? awvalid : arvalid) !== 1'b1) begin
        n_err++;
        $display("FAIL vec_addr_valid: vector %0d at %0t", i, $time);
      end
      if (vecs[i].wr)
        write_body(vecs[i].c, vecs[i].addr, vecs[i].len, vecs[i].delay, vecs[i].br,
                   vecs[i].exp_id);
      else
        read_body(vecs[i].c, vecs[i].addr, vecs[i].len, vecs[i].delay, vecs[i].err_beat,
                  vecs[i].stall_beat, vecs[i].exp_id);
      idle_check();
    end

    // Random request sets against the arbitration model
    for (int i = 0; i < 16; i++) begin
      logic [N-1:0] mask, wr;
      int           g;
      mask = N'($urandom_range(1, (1 << N) - 1));
      wr   = N'($urandom_range(0, (1 << N) - 1));
      for (int c = 0; c < N; c++) set_req(c, $urandom & 32'hFFFF_FFF8, 8'($urandom_range(0, 2)));
      g = pick(mask, mptr);
      grant(mask, wr, g, 1'b0);
      n_checks++;
      if ((wr[g] ? awvalid : arvalid) !== 1'b1) begin
        n_err++;
        $display("FAIL rnd_addr_valid: iteration %0d at %0t", i, $time);
      end
      if (wr[g]) write_body(g, m_addr[g], m_len[g], $urandom_range(0, 2), 2'($urandom), id_of(g));
      else read_body(g, m_addr[g], m_len[g], $urandom_range(0, 2), -1, -1, id_of(g));
      idle_check();
    end

    // Reset asserted during a write burst
    set_req(2, 32'h0000_0700, 8'd3);
    grant(onehot(2), onehot(2), 2, 1'b0);
    awready = 1'b1;
    @(negedge clock);
    `CHK("rw_awvalid", awvalid, 1);
    cyc();
    awready               = 1'b0;
    wd_valid[2]           = 1'b1;
    wd_data[2*DW +: DW]   = 64'h1234;
    wready                = 1'b1;
    @(negedge clock);
    `CHK("rw_wvalid", wvalid, 1);
    cyc();
    reset = 1'b0;
    @(negedge clock);
    `CHK("rw_wvalid_rst", wvalid, 0);
    `CHK("rw_wd_ready_rst", wd_ready, 0);
    `CHK("rw_awvalid_rst", awvalid, 0);
    `CHK("rw_arvalid_rst", arvalid, 0);
    `CHK("rw_bready_rst", bready, 0);
    `CHK("rw_rready_rst", rready, 0);
    `CHK("rw_rsp_valid_rst", rsp_valid, 0);
    `CHK("rw_awaddr_rst", awaddr, 0);
    cyc();
    wd_valid = '0;
    wready   = 1'b0;
    reset    = 1'b1;
    mptr     = 0;
    cyc();
    set_req(1, 32'h0000_0800, 8'd1);
    grant(onehot(1), '0, 1, 1'b0);
    read_body(1, 32'h0000_0800, 8'd1, 1, -1, -1, id_of(1));
    idle_check();

    if (n_err != 0) $display("TEST FAILED");
    else $display("TEST PASSED");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
